ni_param: RTL and testbench
===========================

Name: ni_param

Overview:
- Parametrised network interface between a local core and one NoC router port; successor to the single-purpose counter-test NI.
- TX path: local words are queued in a TX FIFO, framed as {parity, header, payload, dest} and launched onto the channel under router flow control.
- RX path: incoming packets are parity-checked, held in a one-entry buffer and handed to the core with valid/ready.
- Error status and counters are kept for link-integrity testing.

Parameters:
- ADDR_SZ, 4, destination address field width (bits).
- PL_SZ, 32, payload field width.
- HDR_SZ, 8, header width including the parity bit (MSB). The lower HDR_SZ-1 bits hold the sequence number.
- TXQ_DEPTH, 4, TX FIFO entries; must be a power of 2, ≥2.
- ERRCNT_SZ, 8, width of the saturating parity-error counter.

Ports:
- clk, input, 1, clock.
- reset, input, 1, asynchronous, active-high reset.
- id, input, ADDR_SZ, this node's address.
- tx_valid, input, 1, core offers a word.
- tx_ready, output, 1, TX FIFO not full.
- tx_dest, input, ADDR_SZ, destination of the offered word.
- tx_data, input, PL_SZ, payload of the offered word.
- item_out, output, HDR_SZ+PL_SZ+ADDR_SZ, packet to router.
- req, output, 1, item_out valid; one-cycle pulse per packet.
- channel_busy, input, 1, router cannot accept this cycle.
- send_en, input, 1, global send permission.
- item_in, input, HDR_SZ+PL_SZ+ADDR_SZ, packet from router.
- valid, input, 1, item_in valid.
- busy, output, 1, RX buffer full; router must hold.
- rx_valid, output, 1, RX buffer holds a packet.
- rx_ready, input, 1, core consumes the RX packet.
- rx_data, output, PL_SZ, received payload.
- rx_seq, output, HDR_SZ-1, received sequence number.
- error, output, 1, sticky: any parity error or misaddressed packet since reset.
- err_cnt, output, ERRCNT_SZ, saturating count of parity errors.

Behaviour:
- **Reset** (async, reset=1): item_out=0, req=0, busy=0, rx_valid=0, rx_data=0, rx_seq=0, error=0, err_cnt=0. TX FIFO is emptied and seq=0. tx_ready=1 one cycle after reset deasserts.
- **TX enqueue:** occurs when tx_valid & tx_ready; the FIFO stores {tx_dest, tx_data}. tx_ready = !full (combinational from the FIFO count).
- **TX launch:** condition L = send_en & !channel_busy & !empty.
  - On L, at the next edge: item_out[ADDR_SZ-1:0]=dest, the payload field=data, header[HDR_SZ-2:0]=seq, and the MSB = XOR of all lower bits.
  - Also on L: req<=1, pop the FIFO, seq<=seq+1 (wraps mod 2^(HDR_SZ-1)).
  - When L is false: req<=0 and item_out holds its value.
- **TX latency and throughput:** minimum enqueue-to-req latency is 1 cycle (the entry is visible to L the cycle after the push). Back-to-back launches give req high on consecutive cycles.
- **TX simultaneous push and pop:**
  - When full: the pop frees a slot, but tx_ready is still 0 that cycle, so no push occurs.
  - When empty: no launch occurs; the pushed entry is launched the next cycle at the earliest.
- **RX accept:** condition A = valid & !busy.
  - On A: rx_data<=payload field, rx_seq<=header seq, rx_valid<=1, busy<=1.
  - busy is registered and equals rx_valid.
- **RX parity check:** on A, if ^item_in != 0 the packet is still delivered, error<=1 and err_cnt increments, saturating at all-ones.
- **RX address check:** on A, if the dest field != id, error<=1. The packet is still delivered and err_cnt is unchanged.
- **RX drain:** rx_valid & rx_ready clears rx_valid and busy at the next edge.
  - A packet arriving in the same cycle is not accepted, because busy=1 that cycle.
  - The minimum RX cadence is therefore one packet per 2 cycles.
- **Independence:** TX and RX paths are fully independent and may act in the same cycle.
- **Reset mid-operation:** FIFO contents, any in-flight req, and an RX packet held in the buffer are discarded. Nothing is replayed.
- **Stickiness:** error is cleared only by reset.

Decomposition:
- Shared package/include holds:
  - ADDR_SZ/PL_SZ/HDR_SZ defaults.
  - Field offset constants: DEST_LSB=0, PL_LSB=ADDR_SZ, HDR_LSB=ADDR_SZ+PL_SZ, PAR_BIT=top.
  - The packet width constant.
- One sub-module: ni_txq, a synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, reset, push, pop, din, dout, full, empty.
  - Behaviour: show-ahead dout, async reset.

Test Plan:
- **Single TX:** reset, id=0; push dest=1, data=0x12345678 with send_en=1, channel_busy=0 → req pulses exactly one cycle, 1 cycle after the push. item_out has dest=1, payload=0x12345678, seq=0, MSB = XOR of the lower bits.
- **Backpressure:** push 5 words with TXQ_DEPTH=4 while channel_busy=1 → tx_ready=0 after the 4th push. Release channel_busy → 4 consecutive req pulses with seq 0..3 in FIFO order, then the 5th word is accepted.
- **Seq wrap:** send 2^(HDR_SZ-1)+1 packets (129 with defaults) → seq field goes 127→0.
- **RX good:** drive valid with a correctly framed packet (dest=id, payload=0xCAFEF00D, seq=5) while rx_ready=0 → rx_valid=1, busy=1, rx_data=0xCAFEF00D, rx_seq=5, and a second valid is ignored. Assert rx_ready → busy=0 next cycle.
- **RX errors:** flip one payload bit → error=1 and err_cnt=1. Send 300 bad packets → err_cnt saturates at 255. A packet with dest != id sets error while err_cnt is unchanged.
- **Reset mid-flight:** with FIFO holding 3 entries and rx_valid=1, assert reset asynchronously between edges → all outputs return to reset values immediately. After release: no req, and the first launched seq=0.

Source files
------------

// File: rtl/ni_param_pkg.sv
// Shared sizing and packet field layout for the parametrised network interface.
// Packet layout, MSB first: {parity, seq, payload, dest}.
package ni_param_pkg;

    localparam int ADDR_SZ_DEF   = 4;
    localparam int PL_SZ_DEF     = 32;
    localparam int HDR_SZ_DEF    = 8;
    localparam int TXQ_DEPTH_DEF = 4;
    localparam int ERRCNT_SZ_DEF = 8;

    localparam int PKT_W    = HDR_SZ_DEF + PL_SZ_DEF + ADDR_SZ_DEF;
    localparam int DEST_LSB = 0;
    localparam int PL_LSB   = ADDR_SZ_DEF;
    localparam int HDR_LSB  = ADDR_SZ_DEF + PL_SZ_DEF;
    localparam int PAR_BIT  = PKT_W - 1;

    function automatic int pkt_width(int a, int p, int h);
        return a + p + h;
    endfunction

endpackage

// File: rtl/ni_param_if.sv
// Core-side and router-side signals of the network interface.
// slave is the NI's own view; master is the view of whoever drives it.
interface ni_param_if
    import ni_param_pkg::*;
#(
    parameter int ADDR_SZ   = ADDR_SZ_DEF,
    parameter int PL_SZ     = PL_SZ_DEF,
    parameter int HDR_SZ    = HDR_SZ_DEF,
    parameter int ERRCNT_SZ = ERRCNT_SZ_DEF
);
    localparam int W = HDR_SZ + PL_SZ + ADDR_SZ;

    logic [ADDR_SZ-1:0]   id;
    logic                 tx_valid;
    logic                 tx_ready;
    logic [ADDR_SZ-1:0]   tx_dest;
    logic [PL_SZ-1:0]     tx_data;
    logic [W-1:0]         item_out;
    logic                 req;
    logic                 channel_busy;
    logic                 send_en;
    logic [W-1:0]         item_in;
    logic                 valid;
    logic                 busy;
    logic                 rx_valid;
    logic                 rx_ready;
    logic [PL_SZ-1:0]     rx_data;
    logic [HDR_SZ-2:0]    rx_seq;
    logic                 error;
    logic [ERRCNT_SZ-1:0] err_cnt;

    modport slave (
        input  id, tx_valid, tx_dest, tx_data,
        input  channel_busy, send_en, item_in, valid, rx_ready,
        output tx_ready, item_out, req, busy,
        output rx_valid, rx_data, rx_seq, error, err_cnt
    );

    modport master (
        output id, tx_valid, tx_dest, tx_data,
        output channel_busy, send_en, item_in, valid, rx_ready,
        input  tx_ready, item_out, req, busy,
        input  rx_valid, rx_data, rx_seq, error, err_cnt
    );

endinterface

// File: rtl/ni_txq.sv
// Show-ahead synchronous FIFO holding {dest, payload} words for the TX path.
// Pushes into a full queue and pops from an empty one are ignored.
module ni_txq #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_wr;
    logic             w_rd;

    assign full  = (r_cnt == (AW+1)'(DEPTH));
    assign empty = (r_cnt == '0);
    assign w_wr  = push & ~full;
    assign w_rd  = pop & ~empty;
    assign dout  = r_mem[r_rp];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + 1'b1;
            if (w_rd) r_rp <= r_rp + 1'b1;
            unique case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= din;
    end

endmodule

// File: rtl/ni_param.sv
// Network interface: framed TX launch under router flow control, and
// one-entry RX buffer with parity/address checking and error counting.
module ni_param
    import ni_param_pkg::*;
#(
    parameter int ADDR_SZ   = ADDR_SZ_DEF,
    parameter int PL_SZ     = PL_SZ_DEF,
    parameter int HDR_SZ    = HDR_SZ_DEF,
    parameter int TXQ_DEPTH = TXQ_DEPTH_DEF,
    parameter int ERRCNT_SZ = ERRCNT_SZ_DEF
) (
    input logic       clk,
    input logic       reset,
    ni_param_if.slave bus
);
    localparam int W_PKT = pkt_width(ADDR_SZ, PL_SZ, HDR_SZ);
    localparam int W_SEQ = HDR_SZ - 1;
    localparam int W_QE  = ADDR_SZ + PL_SZ;
    localparam int O_DST = DEST_LSB;
    localparam int O_PL  = O_DST + ADDR_SZ;
    localparam int O_HDR = O_PL + PL_SZ;

    logic                 w_push;
    logic                 w_launch;
    logic                 w_full;
    logic                 w_empty;
    logic [W_QE-1:0]      w_q_din;
    logic [W_QE-1:0]      w_q_dout;
    logic [W_PKT-2:0]     w_body;
    logic                 w_accept;
    logic                 w_par_err;
    logic                 w_misaddr;

    logic [W_SEQ-1:0]     r_seq;
    logic [W_PKT-1:0]     r_item;
    logic                 r_req;
    logic                 r_rx_valid;
    logic [PL_SZ-1:0]     r_rx_data;
    logic [W_SEQ-1:0]     r_rx_seq;
    logic                 r_error;
    logic [ERRCNT_SZ-1:0] r_err_cnt;

    assign w_push   = bus.tx_valid & ~w_full;
    assign w_launch = bus.send_en & ~bus.channel_busy & ~w_empty;
    assign w_q_din  = {bus.tx_dest, bus.tx_data};

    ni_txq #(
        .WIDTH (W_QE),
        .DEPTH (TXQ_DEPTH)
    ) u_txq (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_launch),
        .din   (w_q_din),
        .dout  (w_q_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // Queue word is {dest, payload}; the wire order is {seq, payload, dest}.
    assign w_body = {r_seq, w_q_dout[0 +: PL_SZ], w_q_dout[PL_SZ +: ADDR_SZ]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_item <= '0;
            r_req  <= 1'b0;
            r_seq  <= '0;
        end else if (w_launch) begin
            r_item <= {^w_body, w_body};
            r_req  <= 1'b1;
            r_seq  <= r_seq + 1'b1;
        end else begin
            r_req  <= 1'b0;
        end
    end

    assign w_accept  = bus.valid & ~r_rx_valid;
    assign w_par_err = ^bus.item_in;
    assign w_misaddr = (bus.item_in[O_DST +: ADDR_SZ] != bus.id);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_valid <= 1'b0;
            r_rx_data  <= '0;
            r_rx_seq   <= '0;
            r_error    <= 1'b0;
            r_err_cnt  <= '0;
        end else if (w_accept) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= bus.item_in[O_PL +: PL_SZ];
            r_rx_seq   <= bus.item_in[O_HDR +: W_SEQ];
            if (w_par_err | w_misaddr) r_error <= 1'b1;
            if (w_par_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 1'b1;
        end else if (r_rx_valid & bus.rx_ready) begin
            r_rx_valid <= 1'b0;
        end
    end

    assign bus.tx_ready = ~w_full;
    assign bus.item_out = r_item;
    assign bus.req      = r_req;
    assign bus.busy     = r_rx_valid;
    assign bus.rx_valid = r_rx_valid;
    assign bus.rx_data  = r_rx_data;
    assign bus.rx_seq   = r_rx_seq;
    assign bus.error    = r_error;
    assign bus.err_cnt  = r_err_cnt;

endmodule

// File: tb/tb_ni_param.sv
// Directed bench for ni_param: queue-based reference model compared every
// cycle, plus hand-computed packet values at the key points.
module tb_ni_param;
    import ni_param_pkg::*;

    localparam int DEPTH   = TXQ_DEPTH_DEF;
    localparam int SEQ_MOD = 128;

    typedef struct {
        logic [3:0]  dest;
        logic [31:0] data;
    } ent_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int bad = 0;

    ni_param_if bus();

    ni_param dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [43:0] frame(int seq, logic [31:0] d,
                                          logic [3:0] dst);
        logic [42:0] b;
        logic p;
        b = {7'(seq), d, dst};
        p = ($countones(b) % 2) == 1;
        return {p, b};
    endfunction

    // reference model state
    ent_t        q[$];
    int          m_seq = 0;
    logic        m_req = 1'b0;
    logic [43:0] m_item = '0;
    logic        m_rxv = 1'b0;
    logic [31:0] m_rxd = '0;
    logic [6:0]  m_rxs = '0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            q.delete();
            m_seq = 0; m_req = 1'b0; m_item = '0;
            m_rxv = 1'b0; m_rxd = '0; m_rxs = '0;
            m_err = 1'b0; m_cnt = 0;
        end else begin
            int sz;
            bit go, take;
            ent_t e;
            sz   = q.size();
            go   = bus.send_en && !bus.channel_busy && sz > 0;
            take = bus.tx_valid && sz < DEPTH;
            if (go) begin
                e = q.pop_front();
                m_item = frame(m_seq, e.data, e.dest);
                m_seq = (m_seq + 1) % SEQ_MOD;
                m_req = 1'b1;
            end else begin
                m_req = 1'b0;
            end
            if (take) q.push_back('{bus.tx_dest, bus.tx_data});
            if (bus.valid && !m_rxv) begin
                m_rxv = 1'b1;
                m_rxd = bus.item_in[PL_LSB +: 32];
                m_rxs = bus.item_in[HDR_LSB +: 7];
                if ($countones(bus.item_in) % 2 == 1) begin
                    m_err = 1'b1;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
                if (bus.item_in[3:0] != bus.id) m_err = 1'b1;
            end else if (m_rxv && bus.rx_ready) begin
                m_rxv = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        chk("tx_ready", bus.tx_ready, q.size() < DEPTH);
        chk("req", bus.req, m_req);
        chk("item_out", bus.item_out, m_item);
        chk("busy", bus.busy, m_rxv);
        chk("rx_valid", bus.rx_valid, m_rxv);
        chk("rx_data", bus.rx_data, m_rxd);
        chk("rx_seq", bus.rx_seq, m_rxs);
        chk("error", bus.error, m_err);
        chk("err_cnt", bus.err_cnt, m_cnt);
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #2 reset = 1'b0;
        step();
    endtask

    logic [31:0] bp_words [5];

    initial begin
        bus.id = '0; bus.tx_valid = 1'b0; bus.tx_dest = '0;
        bus.tx_data = '0; bus.channel_busy = 1'b0; bus.send_en = 1'b1;
        bus.item_in = '0; bus.valid = 1'b0; bus.rx_ready = 1'b0;
        #1 reset = 1'b1;
        #10;
        chk("rst_item", bus.item_out, 44'h0);
        chk("rst_req", bus.req, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err_cnt, 8'h0);
        #2 reset = 1'b0;
        step();
        chk("rst_tx_ready", bus.tx_ready, 1'b1);

        // single TX
        bus.tx_valid = 1'b1; bus.tx_dest = 4'h1; bus.tx_data = 32'h12345678;
        step();
        bus.tx_valid = 1'b0;
        chk("single_nolaunch", bus.req, 1'b0);
        step();
        chk("single_req", bus.req, 1'b1);
        chk("single_item", bus.item_out, 44'h00123456781);
        step();
        chk("single_req_end", bus.req, 1'b0);
        chk("single_hold", bus.item_out, 44'h00123456781);

        // backpressure
        do_reset();
        bus.channel_busy = 1'b1;
        for (int i = 0; i < 5; i++) bp_words[i] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 4; i++) begin
            bus.tx_valid = 1'b1;
            bus.tx_dest = 4'(i + 2);
            bus.tx_data = bp_words[i];
            step();
        end
        bus.tx_dest = 4'h7; bus.tx_data = bp_words[4];
        chk("bp_full", bus.tx_ready, 1'b0);
        chk("bp_noreq", bus.req, 1'b0);
        bus.channel_busy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bit acc;
            acc = bus.tx_valid && bus.tx_ready;
            step();
            if (acc) bus.tx_valid = 1'b0;
            chk("bp_req", bus.req, 1'b1);
            chk("bp_seq", bus.item_out[HDR_LSB +: 7], 7'(k));
            chk("bp_data", bus.item_out[PL_LSB +: 32], bp_words[k]);
        end
        chk("bp_dest5", bus.item_out[3:0], 4'h7);
        step();
        chk("bp_done", bus.req, 1'b0);

        // sequence wrap
        do_reset();
        for (int i = 0; i <= SEQ_MOD; i++) begin
            bus.tx_valid = 1'b1;
            bus.tx_dest = 4'(i);
            bus.tx_data = 32'(i);
            step();
            if (i == SEQ_MOD) begin
                chk("wrap_127", bus.item_out[HDR_LSB +: 7], 7'd127);
                chk("wrap_127d", bus.item_out[PL_LSB +: 32], 32'd127);
            end
        end
        bus.tx_valid = 1'b0;
        step();
        chk("wrap_req", bus.req, 1'b1);
        chk("wrap_0", bus.item_out[HDR_LSB +: 7], 7'd0);
        chk("wrap_0d", bus.item_out[PL_LSB +: 32], 32'd128);
        step();

        // RX good
        do_reset();
        bus.item_in = 44'h05CAFEF00D0;
        bus.valid = 1'b1;
        step();
        chk("rx_valid", bus.rx_valid, 1'b1);
        chk("rx_busy", bus.busy, 1'b1);
        chk("rx_data", bus.rx_data, 32'hCAFEF00D);
        chk("rx_seq", bus.rx_seq, 7'd5);
        chk("rx_noerr", bus.error, 1'b0);
        bus.item_in = 44'h06111111110;
        step();
        chk("rx_ignored", bus.rx_data, 32'hCAFEF00D);
        bus.valid = 1'b0; bus.rx_ready = 1'b1;
        step();
        chk("rx_drained", bus.busy, 1'b0);
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        chk("rx_second", bus.rx_data, 32'h11111111);
        chk("rx_second_seq", bus.rx_seq, 7'd6);
        step();

        // RX parity errors and saturation
        do_reset();
        bus.item_in = 44'h05CAFEF00D0 ^ 44'h10;
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        chk("perr_flag", bus.error, 1'b1);
        chk("perr_cnt1", bus.err_cnt, 8'd1);
        chk("perr_data", bus.rx_data, 32'hCAFEF00C);
        step();
        bus.valid = 1'b1;
        for (int i = 0; i < 600; i++) step();
        bus.valid = 1'b0;
        chk("perr_sat", bus.err_cnt, 8'd255);
        step();

        // misaddressed packet
        do_reset();
        bus.id = 4'h5;
        bus.item_in = 44'h05CAFEF00D5;
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        chk("addr_ok", bus.error, 1'b0);
        step();
        bus.item_in = 44'h05CAFEF00D3;
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        chk("addr_err", bus.error, 1'b1);
        chk("addr_cnt", bus.err_cnt, 8'd0);
        chk("addr_data", bus.rx_data, 32'hCAFEF00D);
        step();

        // reset mid-flight
        do_reset();
        bus.id = 4'h0; bus.rx_ready = 1'b0; bus.send_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.tx_valid = 1'b1;
            bus.tx_dest = 4'h1;
            bus.tx_data = 32'hB000_0000 + 32'(i);
            step();
        end
        bus.tx_valid = 1'b0;
        bus.item_in = 44'h05CAFEF00D0 ^ 44'h10;
        bus.valid = 1'b1;
        step();
        bus.valid = 1'b0;
        chk("mid_rxv", bus.rx_valid, 1'b1);
        chk("mid_full_err", bus.error, 1'b1);
        bus.send_en = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("mid_rxv0", bus.rx_valid, 1'b0);
        chk("mid_busy0", bus.busy, 1'b0);
        chk("mid_data0", bus.rx_data, 32'h0);
        chk("mid_err0", bus.error, 1'b0);
        chk("mid_cnt0", bus.err_cnt, 8'h0);
        chk("mid_req0", bus.req, 1'b0);
        chk("mid_txr", bus.tx_ready, 1'b1);
        #2 reset = 1'b0;
        step();
        chk("post_noreq", bus.req, 1'b0);
        bus.tx_valid = 1'b1; bus.tx_dest = 4'h2; bus.tx_data = 32'h0000D00D;
        step();
        bus.tx_valid = 1'b0;
        chk("post_noreq2", bus.req, 1'b0);
        step();
        chk("post_req", bus.req, 1'b1);
        chk("post_seq0", bus.item_out[HDR_LSB +: 7], 7'd0);
        chk("post_data", bus.item_out[PL_LSB +: 32], 32'h0000D00D);
        step();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
